// File: rtl/prog_load_ctrl_pkg.sv
// Shared constants for the program-load / CPU-run controller: state
// encodings, default geometry and the core-reset decode.
package prog_load_ctrl_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;
    localparam int RAM_DEPTH  = 2 ** ADDR_W_DEF;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_RSTP = 3'd2;
    localparam logic [2:0] ST_RUN  = 3'd3;
    localparam logic [2:0] ST_HALT = 3'd4;

    localparam logic [7:0] RUN_CNT_MAX = 8'hFF;

    // The core is released from reset only while it runs or sits halted.
    function automatic logic core_live(input logic [2:0] st);
        return (st == ST_RUN) || (st == ST_HALT);
    endfunction

endpackage

// File: rtl/prog_load_ctrl.sv
// Program-load and run controller: streams loader bytes into the program
// RAM, then sequences the CPU core through reset pulse, run and halt.
module prog_load_ctrl
    import prog_load_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    input  logic              run_req,
    input  logic              cpu_hlt,
    output logic              core_rst_n,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              load_done,
    output logic [2:0]        state_o,
    output logic [7:0]        run_cycles
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

    logic [2:0]        state_q;
    logic [2:0]        state_d;
    logic [ADDR_W-1:0] addr_q;
    logic              start_hit;
    logic              accept;
    logic              last_accept;

    logic              wr_vld_p1;
    logic [ADDR_W-1:0] wr_addr_p1;
    logic [DATA_W-1:0] wr_data_p1;

    // Cycle counter steps by one and pins at its maximum instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == RUN_CNT_MAX) ? v : v + 8'd1;
    endfunction

    // A load request is honoured everywhere except the one-cycle reset pulse,
    // and a byte offered alongside a restart is dropped.
    always_comb begin
        start_hit = ld_start && ((state_q == ST_IDLE) || (state_q == ST_LOAD) ||
                                 (state_q == ST_RUN)  || (state_q == ST_HALT));
        ld_ready    = (state_q == ST_LOAD) && !ld_start;
        accept      = ld_ready && ld_valid;
        last_accept = accept && (addr_q == ADDR_LAST);
    end

    // Next-state decode; ld_start has priority in every state that honours it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ld_start)     state_d = ST_LOAD;
                else if (run_req) state_d = ST_RSTP;
            end
            ST_LOAD: begin
                if (ld_start)         state_d = ST_LOAD;
                else if (last_accept) state_d = ST_IDLE;
            end
            ST_RSTP: state_d = ST_RUN;
            ST_RUN: begin
                if (ld_start)     state_d = ST_LOAD;
                else if (cpu_hlt) state_d = ST_HALT;
            end
            ST_HALT: begin
                if (ld_start)     state_d = ST_LOAD;
                else if (run_req) state_d = ST_RSTP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; core reset is decoded from the next state so the
    // output is a flop that tracks the current state with no input path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            core_rst_n <= 1'b0;
        end else begin
            state_q    <= state_d;
            core_rst_n <= core_live(state_d);
        end
    end

    // Load address counter and sticky completion flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            load_done <= 1'b0;
        end else if (start_hit) begin
            addr_q    <= '0;
            load_done <= 1'b0;
        end else if (accept) begin
            addr_q <= addr_q + 1'b1;
            if (last_accept) load_done <= 1'b1;
        end
    end

    // Stage p1: accepted byte presented to the RAM one cycle after accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_vld_p1  <= 1'b0;
            wr_addr_p1 <= '0;
            wr_data_p1 <= '0;
        end else begin
            wr_vld_p1 <= accept;
            if (accept) begin
                wr_addr_p1 <= addr_q;
                wr_data_p1 <= ld_data;
            end
        end
    end

    // Run-cycle counter: cleared during the reset pulse, counts in RUN,
    // holds everywhere else so a halted run can be inspected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cycles <= 8'd0;
        end else if (state_q == ST_RSTP) begin
            run_cycles <= 8'd0;
        end else if (state_q == ST_RUN) begin
            run_cycles <= sat_inc(run_cycles);
        end
    end

    assign ram_we    = wr_vld_p1;
    assign ram_addr  = wr_addr_p1;
    assign ram_wdata = wr_data_p1;
    assign state_o   = state_q;

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Directed bench for prog_load_ctrl: a vector table for basic load handshake
// behaviour plus hand-written sequences for full load, run/halt and reset.
module tb_prog_load_ctrl;
    import prog_load_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ld_start = 1'b0;
    logic       ld_valid = 1'b0;
    logic [7:0] ld_data = 8'h00;
    logic       ld_ready;
    logic       run_req = 1'b0;
    logic       cpu_hlt = 1'b0;
    logic       core_rst_n;
    logic       ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata;
    logic       load_done;
    logic [2:0] state_o;
    logic [7:0] run_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    prog_load_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ld_start   (ld_start),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .run_req    (run_req),
        .cpu_hlt    (cpu_hlt),
        .core_rst_n (core_rst_n),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .load_done  (load_done),
        .state_o    (state_o),
        .run_cycles (run_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic       vl;
        logic [7:0] d;
        logic       rr;
        logic       hl;
        logic [2:0] e_st;
        logic       e_rdy;
        logic       e_we;
        logic [3:0] e_a;
        logic [7:0] e_wd;
        logic       e_dn;
        logic       e_cr;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] snap();
        return {13'd0, state_o, ld_ready, ram_we, ram_addr, ram_wdata, load_done, core_rst_n};
    endfunction

    function automatic logic [31:0] pack_exp(input logic [2:0] s, input logic r, input logic w,
                                             input logic [3:0] a, input logic [7:0] wd,
                                             input logic dn, input logic cr);
        return {13'd0, s, r, w, a, wd, dn, cr};
    endfunction

    task automatic drive(input logic st, input logic vl, input logic [7:0] d,
                         input logic rr, input logic hl);
        ld_start = st;
        ld_valid = vl;
        ld_data  = d;
        run_req  = rr;
        cpu_hlt  = hl;
    endtask

    // One clock with the current inputs, then inputs return to idle.
    task automatic step();
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        #1;
    endtask

    initial begin
        // st vl data  rr hl | state   rdy we addr wdata done core
        tbl[0] = '{1, 0, 8'h00, 1, 0, ST_LOAD, 1, 0, 4'd0, 8'h00, 0, 0};
        tbl[1] = '{0, 1, 8'hAA, 0, 0, ST_LOAD, 1, 1, 4'd0, 8'hAA, 0, 0};
        tbl[2] = '{0, 0, 8'h00, 0, 0, ST_LOAD, 1, 0, 4'd0, 8'hAA, 0, 0};
        tbl[3] = '{0, 1, 8'hBB, 0, 0, ST_LOAD, 1, 1, 4'd1, 8'hBB, 0, 0};
        tbl[4] = '{1, 1, 8'hCC, 0, 0, ST_LOAD, 1, 0, 4'd1, 8'hBB, 0, 0};
        tbl[5] = '{0, 1, 8'hDD, 0, 0, ST_LOAD, 1, 1, 4'd0, 8'hDD, 0, 0};
        tbl[6] = '{0, 0, 8'h00, 1, 1, ST_LOAD, 1, 0, 4'd0, 8'hDD, 0, 0};
        tbl[7] = '{0, 1, 8'hEE, 0, 0, ST_LOAD, 1, 1, 4'd1, 8'hEE, 0, 0};

        // Reset state
        #3;
        check("reset_outputs", snap(), 32'd0);
        check("reset_run_cycles", {24'd0, run_cycles}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        check("idle_after_reset", snap(), 32'd0);

        // Vector table: handshake, gaps, restart discard, ignored run/halt
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].st, tbl[i].vl, tbl[i].d, tbl[i].rr, tbl[i].hl);
            step();
            check($sformatf("vec%0d", i), snap(),
                  pack_exp(tbl[i].e_st, tbl[i].e_rdy, tbl[i].e_we, tbl[i].e_a,
                           tbl[i].e_wd, tbl[i].e_dn, tbl[i].e_cr));
        end

        // Full image load 0x10..0x1F with valid high on every edge
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step();
        check("full_load_start", {29'd0, state_o}, {29'd0, ST_LOAD});
        for (int i = 0; i < RAM_DEPTH; i++) begin
            drive(1'b0, 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
            step();
            check($sformatf("full_wr%0d", i), {19'd0, ram_we, ram_addr, ram_wdata},
                  {19'd0, 1'b1, 4'(i), 8'(8'h10 + i)});
        end
        check("full_load_end", {28'd0, state_o, ld_ready, load_done},
              {28'd0, ST_IDLE, 1'b0, 1'b1});
        step();
        check("no_write_after_load", {31'd0, ram_we}, 32'd0);

        // Run: 1-cycle reset pulse, counting and saturation
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step();
        check("rstp_entry", {27'd0, state_o, core_rst_n, load_done}, {27'd0, ST_RSTP, 1'b0, 1'b1});
        step();
        check("run_entry", {19'd0, state_o, core_rst_n, load_done, run_cycles},
              {19'd0, ST_RUN, 1'b1, 1'b1, 8'd0});
        repeat (200) step();
        check("run_count_200", {24'd0, run_cycles}, 32'd200);
        repeat (100) step();
        check("run_count_sat", {24'd0, run_cycles}, 32'd255);

        // Halt at saturation, then restart from HALT
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        step();
        check("halt_sat", {20'd0, state_o, core_rst_n, run_cycles}, {20'd0, ST_HALT, 1'b1, 8'd255});
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step();
        check("halt_restart_pulse", {28'd0, state_o, core_rst_n}, {28'd0, ST_RSTP, 1'b0});
        step();
        check("rerun_cleared", {20'd0, state_o, core_rst_n, run_cycles}, {20'd0, ST_RUN, 1'b1, 8'd0});
        repeat (5) step();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        step();
        check("halt_at_6", {20'd0, state_o, core_rst_n, run_cycles}, {20'd0, ST_HALT, 1'b1, 8'd6});
        repeat (3) step();
        check("halt_hold", {20'd0, state_o, core_rst_n, run_cycles}, {20'd0, ST_HALT, 1'b1, 8'd6});

        // HALT with both requests: load wins and clears load_done
        drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        step();
        check("halt_start_wins", {27'd0, state_o, core_rst_n, load_done}, {27'd0, ST_LOAD, 1'b0, 1'b0});

        // Restart at byte 7: offered byte discarded, next lands at address 0
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
            step();
            check($sformatf("part_wr%0d", i), {19'd0, ram_we, ram_addr, ram_wdata},
                  {19'd0, 1'b1, 4'(i), 8'(8'h40 + i)});
        end
        drive(1'b1, 1'b1, 8'h99, 1'b0, 1'b0);
        step();
        check("restart_discard", {28'd0, state_o, ram_we}, {28'd0, ST_LOAD, 1'b0});
        drive(1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
        step();
        check("restart_addr0", {19'd0, ram_we, ram_addr, ram_wdata}, {19'd0, 1'b1, 4'd0, 8'h55});

        // Asynchronous reset between edges mid-load
        drive(1'b0, 1'b1, 8'h66, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("pre_reset_write", {19'd0, ram_we, ram_addr, ram_wdata}, {19'd0, 1'b1, 4'd1, 8'h66});
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", snap(), 32'd0);
        check("async_reset_cycles", {24'd0, run_cycles}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("in_reset_no_we%0d", i), {31'd0, ram_we}, 32'd0);
        end
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 8'h77, 1'b0, 1'b1);
            step();
            check($sformatf("post_reset_idle%0d", i), snap(), 32'd0);
        end

        // RUN: ld_start beats cpu_hlt
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step();
        step();
        check("run_again", {28'd0, state_o, core_rst_n}, {28'd0, ST_RUN, 1'b1});
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        step();
        check("run_start_wins", {27'd0, state_o, core_rst_n, ld_ready}, {27'd0, ST_LOAD, 1'b0, 1'b1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_load_ctrl.md
PROG_LOAD_CTRL -- requirements
Module: prog_load_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 4: RAM address width; RAM depth is 2**ADDR_W.
REQ-002 SHALL have parameter DATA_W, default 8: RAM and bus data width.
REQ-003 SHALL have one clock and asynchronous active-low reset: clk in 1, rising-edge clock; rst_n in 1, asynchronous active-low reset.
REQ-004 SHALL have ld_start in 1: single-cycle request to begin program load at address 0.
REQ-005 SHALL have ld_valid in 1: loader byte present on ld_data.
REQ-006 SHALL have ld_data in DATA_W: program byte.
REQ-007 SHALL have ld_ready out 1: controller accepts a byte this cycle.
REQ-008 SHALL have run_req in 1: single-cycle request to start or restart the CPU.
REQ-009 SHALL have cpu_hlt in 1: synchronous HLT-opcode-reached flag from the CPU control unit.
REQ-010 SHALL have core_rst_n out 1: registered active-low reset to the CPU core.
REQ-011 SHALL have ram_we out 1: RAM write strobe.
REQ-012 SHALL have ram_addr out ADDR_W: RAM write address.
REQ-013 SHALL have ram_wdata out DATA_W: RAM write data.
REQ-014 SHALL have load_done out 1: sticky flag, full image written.
REQ-015 SHALL have state_o out 3: current FSM state encoding.
REQ-016 SHALL have run_cycles out 8: saturating count of cycles spent in RUN.

Function
REQ-017 SHALL implement the states IDLE, LOAD, RSTP, RUN and HALT; state_o SHALL equal the state register.
REQ-018 IDLE: ld_start -> LOAD; otherwise run_req -> RSTP; ld_start SHALL win when both are asserted.
REQ-019 LOAD: ld_ready SHALL be 1; a byte is accepted when ld_valid & ld_ready; the address counter starts at 0 on entry.
REQ-020 The accepted byte SHALL appear on ram_wdata/ram_addr with ram_we=1 exactly 1 cycle after acceptance, for 1 cycle; at most one byte is accepted per cycle.
REQ-021 The address counter SHALL increment after each accept.
REQ-022 Accept at address 2**ADDR_W-1 SHALL cause the counter to wrap to 0, set load_done the same cycle, drop ld_ready, and transition LOAD -> IDLE.
REQ-023 ld_start during LOAD SHALL restart the load at address 0, clear load_done, and discard any byte offered that cycle.
REQ-024 run_req and cpu_hlt SHALL be ignored in LOAD.
REQ-025 RSTP: core_rst_n SHALL be 0 for exactly 1 cycle; the FSM then goes to RUN unconditionally and run_cycles clears to 0.
REQ-026 RUN: core_rst_n=1; run_cycles SHALL increment each cycle and saturate at 255 with no wrap.
REQ-027 In RUN, cpu_hlt=1 SHALL cause RUN -> HALT; ld_start SHALL cause RUN -> LOAD with priority over cpu_hlt.
REQ-028 HALT: core_rst_n stays 1, so the core stays frozen on HLT; run_cycles SHALL hold.
REQ-029 In HALT, run_req -> RSTP and ld_start -> LOAD, with ld_start winning.
REQ-030 core_rst_n SHALL be 0 in IDLE, LOAD and RSTP, and 1 in RUN and HALT.
REQ-031 core_rst_n SHALL be registered, with no combinational path from any input.
REQ-032 load_done SHALL clear on ld_start and stay set through RSTP, RUN and HALT.
REQ-033 ram_we SHALL never be asserted outside LOAD, except the final write of a load, which completes 1 cycle after the LOAD -> IDLE transition.
REQ-034 Undefined state encodings SHALL recover to IDLE on the next clock.

Reset
REQ-035 Assertion of rst_n SHALL force, asynchronously: state IDLE, core_rst_n=0, ld_ready=0, ram_we=0, ram_addr=0, ram_wdata=0, load_done=0, run_cycles=0, address counter=0.
REQ-036 Reset mid-LOAD SHALL abandon the load with no further ram_we; the RAM contents are then undefined and load_done=0.
REQ-037 After rst_n deasserts, the first state change SHALL occur on the first rising edge with ld_start or run_req asserted.

Structure
REQ-038 A shared package SHALL hold the state encoding constants (IDLE=0, LOAD=1, RSTP=2, RUN=3, HALT=4), the default ADDR_W/DATA_W values, and the RAM depth.
REQ-039 The block SHALL be one module with no sub-module; the address counter and cycle counter are inline.

Verification
REQ-040 Reset then a load of 16 bytes 0x10..0x1F with ld_valid held high -> ram_we pulses at addr 0..15 with data 0x10..0x1F, one cycle after each accept; load_done=1; state IDLE.
REQ-041 Load with ld_valid toggling 1-0-1 -> no write during idle cycles; the address advances only on accept.
REQ-042 run_req from IDLE -> core_rst_n low for exactly 1 cycle, then high; run_cycles reaches 255 and stays 255 after 300 cycles.
REQ-043 cpu_hlt=1 in RUN -> HALT, core_rst_n=1, run_cycles frozen; a following run_req -> 1-cycle core_rst_n low pulse, then RUN with run_cycles=0.
REQ-044 ld_start at byte 7 of a load -> next accepted byte written at addr 0; load_done cleared; ld_start and run_req in the same cycle in IDLE -> LOAD.
REQ-045 rst_n asserted mid-load between edges -> all outputs at reset values immediately, with no ram_we afterward.
